tx_nco_tune_ctrl: RTL and testbench

- Sequences the TX NCO's tuning word. Accepts new phase-increment targets from the control side over a valid/ready handshake.
- Glides the NCO phase increment linearly to each target and drives the NCO clock enable.
- Tracks settling through the NCO pipeline, then flags the output as frequency-locked.
- Sits between the register/control interface and the NCO core; its outputs feed the NCO's clken and phi_inc_i inputs.

---
 rtl/tx_nco_tune_ctrl_if.sv | 31 +++
 rtl/tx_nco_tune_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tx_nco_tune_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_nco_tune_ctrl_if.sv
// rtl/tx_nco_tune_ctrl_if.sv - tuning-word update handshake between control and tx_nco_tune_ctrl
//
// Signals:
//   upd_valid    new target tuning word offered (control -> block)
//   upd_ready    block can accept a target     (block -> control)
//   upd_phi_inc  target tuning word, APR bits
//   glide_step   per-enabled-cycle glide step, STEP_W bits, sampled at accept
// Modports: master = control side, slave = tx_nco_tune_ctrl.
interface tx_nco_tune_ctrl_if #(
    parameter int APR    = 32,
    parameter int STEP_W = 16
);
    logic              upd_valid;
    logic              upd_ready;
    logic [APR-1:0]    upd_phi_inc;
    logic [STEP_W-1:0] glide_step;

    modport master (
        output upd_valid,
        output upd_phi_inc,
        output glide_step,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_phi_inc,
        input  glide_step,
        output upd_ready
    );
endinterface

// File: rtl/tx_nco_tune_ctrl.sv
// rtl/tx_nco_tune_ctrl.sv - TX NCO tuning-word sequencer with linear glide and lock tracking
//
// Accepts phase-increment targets, glides nco_phi_inc toward each target in
// steps of glide_step (shortest path modulo 2^APR), gates the NCO with
// nco_clken, waits SETTLE_CYC enabled cycles for the NCO pipeline to flush
// and then raises freq_locked.
//
// Optional feature macro: TX_NCO_TUNE_CTRL_GLIDE_EN
//   defined   - RAMP state built, glide_step controls the glide.
//   undefined - no RAMP; every differing target is applied on the accept edge.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   run                 NCO run request (registered into nco_clken)
//   upd                 slave modport: upd_valid/upd_ready/upd_phi_inc/glide_step
//   nco_out_valid       NCO out_valid
//   nco_clken           NCO clock enable
//   nco_phi_inc         tuning word to the NCO
//   busy                RAMP or SETTLE in progress
//   freq_locked         NCO output reflects current target
//   tx_sample_valid     nco_out_valid && freq_locked && nco_clken
module tx_nco_tune_ctrl #(
    parameter int APR        = 32,
    parameter int STEP_W     = 16,
    parameter int SETTLE_CYC = 12,
    parameter int CW         = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    tx_nco_tune_ctrl_if.slave     upd,
    input  logic                  nco_out_valid,
    output logic                  nco_clken,
    output logic [APR-1:0]        nco_phi_inc,
    output logic                  busy,
    output logic                  freq_locked,
    output logic                  tx_sample_valid
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    state_t            state, state_nxt;
    logic [APR-1:0]    target, target_nxt;
    logic [APR-1:0]    phi_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              locked_nxt;
    logic              accept;

    assign upd.upd_ready   = (state != RAMP);
    assign accept          = upd.upd_valid && upd.upd_ready;
    assign busy            = (state != IDLE);
    assign tx_sample_valid = nco_out_valid && freq_locked && nco_clken;

`ifdef TX_NCO_TUNE_CTRL_GLIDE_EN
    // Signed distance to the target modulo 2^APR. The most negative value is
    // treated as positive so the half-circle tie always glides upward; its
    // magnitude is then the unsigned value itself.
    logic [APR-1:0] diff, diff_mag, step_ext;
    logic           diff_min, diff_down;

    assign diff      = target - nco_phi_inc;
    assign diff_min  = (diff == {1'b1, {(APR-1){1'b0}}});
    assign diff_down = diff[APR-1] && !diff_min;
    assign diff_mag  = diff_down ? ('0 - diff) : diff;
    assign step_ext  = APR'(step);
`else
    logic unused_step;
    assign unused_step = ^step;
`endif

    always_comb begin
        state_nxt  = state;
        phi_nxt    = nco_phi_inc;
        target_nxt = target;
        step_nxt   = step;
        cnt_nxt    = cnt;
        locked_nxt = freq_locked;

        case (state)
`ifdef TX_NCO_TUNE_CTRL_GLIDE_EN
            RAMP: begin
                if (nco_clken) begin
                    if (diff_mag <= step_ext) begin
                        phi_nxt   = target;
                        cnt_nxt   = '0;
                        state_nxt = SETTLE;
                    end else if (diff_down) begin
                        phi_nxt = nco_phi_inc - step_ext;
                    end else begin
                        phi_nxt = nco_phi_inc + step_ext;
                    end
                end
            end
`endif
            SETTLE: begin
                if (nco_clken) begin
                    if (cnt == CNT_LAST) begin
                        // Terminal count holds until the NCO reports valid output.
                        if (nco_out_valid) begin
                            locked_nxt = 1'b1;
                            state_nxt  = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // An accept (IDLE or SETTLE only) takes priority over settle progress:
        // a retarget always restarts the settle window.
        if (accept) begin
            target_nxt = upd.upd_phi_inc;
            step_nxt   = upd.glide_step;
            cnt_nxt    = '0;
            state_nxt  = state;
            locked_nxt = freq_locked;
            if (upd.upd_phi_inc != nco_phi_inc) begin
                locked_nxt = 1'b0;
`ifdef TX_NCO_TUNE_CTRL_GLIDE_EN
                if (upd.glide_step == '0) begin
                    phi_nxt   = upd.upd_phi_inc;
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = RAMP;
                end
`else
                phi_nxt   = upd.upd_phi_inc;
                state_nxt = SETTLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            nco_phi_inc <= '0;
            nco_clken   <= 1'b0;
            target      <= '0;
            step        <= '0;
            cnt         <= '0;
            freq_locked <= 1'b0;
        end else begin
            state       <= state_nxt;
            nco_phi_inc <= phi_nxt;
            nco_clken   <= run;
            target      <= target_nxt;
            step        <= step_nxt;
            cnt         <= cnt_nxt;
            freq_locked <= locked_nxt;
        end
    end
endmodule

// File: tb/tb_tx_nco_tune_ctrl.sv
// tb/tb_tx_nco_tune_ctrl.sv - self-checking bench for tx_nco_tune_ctrl
module tb_tx_nco_tune_ctrl;
    localparam int APR        = 32;
    localparam int STEP_W     = 16;
    localparam int SETTLE_CYC = 12;
`ifdef TX_NCO_TUNE_CTRL_GLIDE_EN
    localparam bit GLIDE = 1'b1;
`else
    localparam bit GLIDE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           run;
    logic           nco_out_valid;
    logic           nco_clken;
    logic [APR-1:0] nco_phi_inc;
    logic           busy;
    logic           freq_locked;
    logic           tx_sample_valid;

    tx_nco_tune_ctrl_if #(.APR(APR), .STEP_W(STEP_W)) upd ();

    tx_nco_tune_ctrl #(.APR(APR), .STEP_W(STEP_W), .SETTLE_CYC(SETTLE_CYC), .CW(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (run),
        .upd             (upd),
        .nco_out_valid   (nco_out_valid),
        .nco_clken       (nco_clken),
        .nco_phi_inc     (nco_phi_inc),
        .busy            (busy),
        .freq_locked     (freq_locked),
        .tx_sample_valid (tx_sample_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed observation: {clken, phi, ready, busy, locked, tx_valid}
    function automatic logic [63:0] obs();
        return 64'({nco_clken, nco_phi_inc, upd.upd_ready, busy, freq_locked, tx_sample_valid});
    endfunction

    function automatic logic [63:0] pack(input bit ck, input bit [31:0] p, input bit r,
                                         input bit b, input bit l, input bit t);
        return 64'({ck, p, r, b, l, t});
    endfunction

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic drive(input bit rn, input bit r, input bit v, input bit [31:0] p,
                         input bit [15:0] s, input bit ov);
        reset_n           = rn;
        run               = r;
        upd.upd_valid     = v;
        upd.upd_phi_inc   = p;
        upd.glide_step    = s;
        nco_out_valid     = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit ck, input bit [31:0] p,
                              input bit r, input bit b, input bit l, input bit t);
        check(name, obs(), pack(ck, p, r, b, l, t));
    endtask

    // ---------------- behavioural reference model ----------------
    bit [31:0] m_phi, m_tgt;
    int        m_step, m_mode, m_cnt;   // mode: 0 idle, 1 gliding, 2 settling
    bit        m_locked, m_clken;

    task automatic model_edge(input bit rn, input bit r, input bit v, input bit [31:0] p,
                              input bit [15:0] s, input bit ov);
        bit     en;
        int     d;
        longint dl, mag;
        if (!rn) begin
            m_phi = 0; m_tgt = 0; m_step = 0; m_mode = 0; m_cnt = 0;
            m_locked = 0; m_clken = 0;
            return;
        end
        en      = m_clken;
        m_clken = r;
        if (v && m_mode != 1) begin
            m_tgt  = p;
            m_step = int'(s);
            m_cnt  = 0;
            if (p != m_phi) begin
                m_locked = 0;
                if (GLIDE && s != 0) m_mode = 1;
                else begin
                    m_phi  = p;
                    m_mode = 2;
                end
            end
            return;
        end
        if (!en) return;
        if (m_mode == 1) begin
            d  = int'(m_tgt - m_phi);
            dl = longint'(d);
            if (dl == -64'sd2147483648) dl = 64'sd2147483648;
            mag = (dl < 0) ? -dl : dl;
            if (mag <= longint'(m_step)) begin
                m_phi  = m_tgt;
                m_mode = 2;
                m_cnt  = 0;
            end else if (dl > 0) m_phi = m_phi + 32'(m_step);
            else m_phi = m_phi - 32'(m_step);
        end else if (m_mode == 2) begin
            if (m_cnt == SETTLE_CYC - 1) begin
                if (ov) begin
                    m_locked = 1;
                    m_mode   = 0;
                end
            end else m_cnt++;
        end
    endtask

    task automatic model_cycle(input bit rn, input bit r, input bit v, input bit [31:0] p,
                               input bit [15:0] s, input bit ov);
        model_edge(rn, r, v, p, s, ov);
        drive(rn, r, v, p, s, ov);
        check("random", obs(), pack(m_clken, m_phi, m_mode != 1, m_mode != 0, m_locked,
                                    ov && m_locked && m_clken));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        run;
        bit        valid;
        bit [31:0] phi;
        bit [15:0] step;
        bit        ov;
        bit        e_clken;
        bit [31:0] e_phi;
        bit        e_ready;
        bit        e_busy;
        bit        e_locked;
        bit        e_txv;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit v, input bit [31:0] p, input bit ov,
                                input bit ck, input bit [31:0] ep, input bit eb,
                                input bit el, input bit et);
        vec_t x;
        x.run = r; x.valid = v; x.phi = p; x.step = 16'h0; x.ov = ov;
        x.e_clken = ck; x.e_phi = ep; x.e_ready = 1'b1; x.e_busy = eb;
        x.e_locked = el; x.e_txv = et;
        tbl.push_back(x);
    endfunction

    initial begin
        bit [31:0] p;
        bit [15:0] s;

        // Step-0 accepts behave identically with and without the glide feature.
        add(1, 0, 32'h0,         1, 1, 32'h0,         0, 0, 0);
        add(1, 1, 32'h0100_0000, 1, 1, 32'h0100_0000, 1, 0, 0);
        for (int i = 0; i < 11; i++) add(1, 0, 32'h0, 1, 1, 32'h0100_0000, 1, 0, 0);
        add(1, 0, 32'h0,         1, 1, 32'h0100_0000, 0, 1, 1);   // 12th enabled cycle
        add(1, 1, 32'h0100_0000, 1, 1, 32'h0100_0000, 0, 1, 1);   // same target: no change
        add(1, 1, 32'h0200_0000, 1, 1, 32'h0200_0000, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 32'h0, 1, 1, 32'h0200_0000, 1, 0, 0);
        add(1, 1, 32'h0300_0000, 1, 1, 32'h0300_0000, 1, 0, 0);   // retarget at count 6
        for (int i = 0; i < 11; i++) add(1, 0, 32'h0, 1, 1, 32'h0300_0000, 1, 0, 0);
        add(1, 0, 32'h0,         0, 1, 32'h0300_0000, 1, 0, 0);   // terminal, no out_valid
        add(0, 0, 32'h0,         0, 0, 32'h0300_0000, 1, 0, 0);
        add(0, 0, 32'h0,         1, 0, 32'h0300_0000, 1, 0, 0);   // disabled edge
        add(1, 0, 32'h0,         1, 1, 32'h0300_0000, 1, 0, 0);   // still disabled edge
        add(1, 0, 32'h0,         1, 1, 32'h0300_0000, 0, 1, 1);

        upd.upd_valid = 0; upd.upd_phi_inc = 0; upd.glide_step = 0;
        reset_n = 0; run = 1; nco_out_valid = 1;
        #2;

        drive(0, 1, 0, 0, 0, 1);
        expect_out("reset", 0, 32'h0, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(1, tbl[i].run, tbl[i].valid, tbl[i].phi, tbl[i].step, tbl[i].ov);
            check($sformatf("tbl[%0d]", i), obs(),
                  pack(tbl[i].e_clken, tbl[i].e_phi, tbl[i].e_ready, tbl[i].e_busy,
                       tbl[i].e_locked, tbl[i].e_txv));
        end

`ifdef TX_NCO_TUNE_CTRL_GLIDE_EN
        drive(0, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 1, 32'h1000, 16'h0, 1);
        expect_out("seed_1000", 1, 32'h1000, 1, 1, 0, 0);
        drive(1, 1, 1, 32'h1A00, 16'h0400, 1);
        expect_out("ramp_accept", 1, 32'h1000, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("ramp_1", 1, 32'h1400, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("ramp_2", 1, 32'h1800, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("ramp_3", 1, 32'h1A00, 1, 1, 0, 0);

        drive(1, 1, 1, 32'h3A00, 16'h0400, 1);
        expect_out("run_accept", 1, 32'h1A00, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("run_s1", 1, 32'h1E00, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("run_s2", 1, 32'h2200, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 1); expect_out("run_low0", 0, 32'h2600, 0, 1, 0, 0);
        for (int i = 1; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 1);
            expect_out($sformatf("run_low%0d", i), 0, 32'h2600, 0, 1, 0, 0);
        end
        drive(1, 1, 0, 0, 0, 1); expect_out("run_back", 1, 32'h2600, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("run_resume", 1, 32'h2A00, 0, 1, 0, 0);

        drive(0, 1, 1, 32'h1234, 16'h1, 1);
        expect_out("reset_mid_ramp", 0, 32'h0, 1, 0, 0, 0);

        drive(1, 1, 1, 32'hFFFF_FF00, 16'h0, 1);
        expect_out("wrap_seed", 1, 32'hFFFF_FF00, 1, 1, 0, 0);
        drive(1, 1, 1, 32'h0000_0100, 16'h0080, 1);
        expect_out("wrap_accept", 1, 32'hFFFF_FF00, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("wrap_1", 1, 32'hFFFF_FF80, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("wrap_2", 1, 32'h0000_0000, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("wrap_3", 1, 32'h0000_0080, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("wrap_4", 1, 32'h0000_0100, 1, 1, 0, 0);

        drive(0, 1, 0, 0, 0, 1);
        drive(1, 1, 1, 32'h8000_0000, 16'hFFFF, 1);
        drive(1, 1, 0, 0, 0, 1);
        expect_out("half_circle_up", 1, 32'h0000_FFFF, 0, 1, 0, 0);

        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 1, 32'h0500, 16'h0100, 1);
        expect_out("idle_run_accept", 0, 32'h0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 1); expect_out("idle_run_wait", 0, 32'h0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("idle_run_en", 1, 32'h0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1); expect_out("idle_run_step", 1, 32'h0100, 0, 1, 0, 0);
`else
        drive(0, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 1, 32'h1A00, 16'h0400, 1);
        expect_out("jump_ignores_step", 1, 32'h1A00, 1, 1, 0, 0);
        drive(1, 1, 1, 32'hFFFF_FF00, 16'h0080, 1);
        expect_out("jump_in_settle", 1, 32'hFFFF_FF00, 1, 1, 0, 0);
        drive(0, 1, 1, 32'h1234, 16'h1, 1);
        expect_out("reset_mid_settle", 0, 32'h0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 1, 32'h0500, 16'h0100, 1);
        expect_out("idle_run_accept", 0, 32'h0500, 1, 1, 0, 0);
`endif

        // Randomized run against the reference model.
        model_cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            p = m_phi + $urandom_range(0, 32'h40000) - 32'h20000;
            if ($urandom_range(0, 7) == 0) p = m_phi;
            s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h200, 16'hFFFF));
            model_cycle(($urandom_range(0, 299) != 0),
                        ($urandom_range(0, 7) != 0),
                        ($urandom_range(0, 3) == 0),
                        p, s,
                        ($urandom_range(0, 7) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
